// File: rtl/reg_file_wb_sink.sv
// Architectural register file fed by the write-back stage.
// Two combinational decode read ports with optional write-through bypass,
// one committed-only debug read port, and a running count of committed writes.
// Register 0 is hardwired to zero.
module reg_file_wb_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS_EN  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_RegWriteW,
  input  logic [ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic [DATA_WIDTH-1:0] i_ResultW,
  input  logic [ADDR_WIDTH-1:0] i_A1,
  input  logic [ADDR_WIDTH-1:0] i_A2,
  input  logic [ADDR_WIDTH-1:0] i_DbgA,
  output logic [DATA_WIDTH-1:0] o_RD1,
  output logic [DATA_WIDTH-1:0] o_RD2,
  output logic [DATA_WIDTH-1:0] o_DbgRD,
  output logic [15:0]           o_WriteCount
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [15:0]           wcount;
  logic                  wr_en;

  // A write only counts when enabled and not aimed at $zero. The enable is
  // evaluated first so an unknown index with the enable low resolves to 0.
  assign wr_en = i_RegWriteW && (i_WriteRegW != '0);

  // Read-port selection: $zero first, then a same-cycle write-back hit
  // (when bypass is built in), otherwise the committed contents.
  function automatic logic [DATA_WIDTH-1:0] rd_sel(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] r;
    r = stored;
    if (addr == '0) begin
      r = '0;
    end else if ((BYPASS_EN != 0) && (we == 1'b1)) begin
      if (waddr == addr) begin
        r = wdata;
      end
    end
    return r;
  endfunction

  // Commit write-back results and count them; reset clears everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs   <= '{default: '0};
      wcount <= '0;
    end else if (wr_en) begin
      regs[i_WriteRegW] <= i_ResultW;
      wcount            <= wcount + 16'd1;
    end
  end

  // Decode read ports (bypassed) and debug port (committed contents only).
  always_comb begin
    o_RD1   = rd_sel(i_A1, regs[i_A1], i_RegWriteW, i_WriteRegW, i_ResultW);
    o_RD2   = rd_sel(i_A2, regs[i_A2], i_RegWriteW, i_WriteRegW, i_ResultW);
    o_DbgRD = (i_DbgA == '0) ? '0 : regs[i_DbgA];
  end

  assign o_WriteCount = wcount;

endmodule

// File: doc/reg_file_wb_sink.md
Name: reg_file_wb_sink

Overview:
- Architectural register file that consumes the write-back stage result (ResultW, WriteRegW, RegWriteW).
- Serves the two decode-stage source-operand read ports.
- Writes commit on the rising clock edge.
- An internal write-through bypass replaces the classic "write first half, read second half" trick, so decode sees a same-cycle write-back without a separate forwarding path.
- Register 0 is hardwired to zero (MIPS $zero).

Parameters:
- DATA_WIDTH, 32, width of each register and of the write/read data.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = a same-cycle write to a read address is forwarded to that read output; 0 = reads return only committed contents.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high; clears all registers.
- i_RegWriteW  input  1  write enable from write-back.
- i_WriteRegW  input  ADDR_WIDTH  destination register index.
- i_ResultW  input  DATA_WIDTH  write data (write-back mux output).
- i_A1  input  ADDR_WIDTH  read address, port 1 (rs).
- i_A2  input  ADDR_WIDTH  read address, port 2 (rt).
- i_DbgA  input  ADDR_WIDTH  debug/testbench read address.
- o_RD1  output  DATA_WIDTH  read data, port 1.
- o_RD2  output  DATA_WIDTH  read data, port 2.
- o_DbgRD  output  DATA_WIDTH  debug read data; committed contents only, never bypassed.
- o_WriteCount  output  16  number of committed non-zero-index writes since reset; wraps modulo 2**16.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH wide.
- Reset: i_rst high asynchronously forces all registers and o_WriteCount to 0, regardless of clock.
  - All read outputs are therefore 0 while reset is held.
  - A write presented in the same cycle that reset deasserts is ignored unless a rising edge occurs with i_rst low.
- Write: on rising i_clk with i_rst low, i_RegWriteW=1 and i_WriteRegW != 0:
  - register[i_WriteRegW] <= i_ResultW;
  - o_WriteCount <= o_WriteCount + 1.
- Discarded writes: with i_WriteRegW == 0, or with i_RegWriteW=0, nothing is stored and the count does not change.
- Read: combinational, zero latency.
  - o_RDn = 0 if i_An == 0.
  - Else, if BYPASS_EN=1 and i_RegWriteW=1 and i_WriteRegW == i_An, then o_RDn = i_ResultW.
  - Else o_RDn = register[i_An].
- Bypass priority: zero-index check > bypass > stored value. A write to $0 is never forwarded.
- Both read ports are independent: both may hit the same register, and both may be bypassed simultaneously.
- o_DbgRD = register[i_DbgA]; index 0 reads 0. No bypass on this port.
- Back-to-back writes to the same index: last write wins. Each write increments the count.
- o_WriteCount wrap: 16'hFFFF + 1 -> 16'h0000, no saturation.
- X-safety: with i_RegWriteW=0, unknown i_WriteRegW or i_ResultW must not corrupt state or bypass.

Test Plan:
- Reset: assert i_rst mid-run after writing R5=0x1234 -> o_RD1 (A1=5), o_DbgRD and o_WriteCount all read 0 immediately, before any clock edge.
- Basic write/read: write R7=0xDEADBEEF, next cycle A1=7, A2=7 -> o_RD1=o_RD2=0xDEADBEEF; o_WriteCount=1.
- $zero: RegWriteW=1, WriteRegW=0, ResultW=0xFFFFFFFF, A1=0 -> o_RD1=0 in that cycle and after the edge; o_WriteCount unchanged.
- Bypass, BYPASS_EN=1: R3 holds 0x11; present write R3=0x22 with A1=3, A2=4 -> o_RD1=0x22 in the same cycle, o_DbgRD (DbgA=3)=0x11 until the edge, then 0x22.
- Bypass, BYPASS_EN=0: same stimulus -> o_RD1=0x11 until the edge, then 0x22.
- Counter wrap: 65536 writes to R1 -> o_WriteCount returns to 0; R1 holds the last written value.
